pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, sets the maximum memory wait cycles before error (range 1..255).
REQ-002 Parameter CNT_W, default 16, sets the width of the stall-cycle statistic counter.
REQ-003 The module SHALL provide the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- src1  in  4  Rn index of the instruction in ID.
- src2  in  4  Rm/Rd index of the instruction in ID.
- use_src1  in  1  ID instruction reads src1.
- two_src  in  1  ID instruction reads src2.
- exe_wb_en  in  1  WB_EN registered at ID/EXE output.
- exe_mem_r_en  in  1  MEM_R_EN registered at ID/EXE output.
- exe_dest  in  4  Dest registered at ID/EXE output.
- mem_wb_en  in  1  WB_EN at EXE/MEM output.
- mem_dest  in  4  Dest at EXE/MEM output.
- branch_taken  in  1  B at ID/EXE output (branch resolving in EXE).
- mem_req  in  1  MEM stage performs a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- hazard_freeze  out  1  freeze for the PC and IF/ID register; drives bubble into ID/EXE.
- flush  out  1  flush for the IF/ID and ID/EXE registers.
- mem_stall  out  1  freeze for all pipeline registers.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with hazard_freeze or mem_stall.

Function
REQ-004 The FSM SHALL have states RUN, MEM_WAIT and ERR, each held in a registered state.
REQ-005 RUN->MEM_WAIT SHALL occur when mem_req=1 and mem_ready=0.
REQ-006 MEM_WAIT->RUN SHALL occur on mem_ready=1.
REQ-007 MEM_WAIT->ERR SHALL occur when wait_cnt reaches MEM_TIMEOUT with mem_ready=0.
REQ-008 ERR SHALL be left only by rst.
REQ-009 wait_cnt (8-bit) SHALL clear on entry to MEM_WAIT, increment each MEM_WAIT cycle, and clear on return to RUN.
REQ-010 mem_stall SHALL be combinational: 1 when (RUN & mem_req & ~mem_ready), 1 in MEM_WAIT while mem_ready=0, and 1 always in ERR.
REQ-011 mem_stall SHALL drop to 0 in the same cycle mem_ready=1 arrives in MEM_WAIT.
REQ-012 mem_err SHALL be registered and equal 1 exactly while state=ERR.
REQ-013 The raw hazard is src1 match (use_src1 & src1==Dest) or src2 match (two_src & src2==Dest) against a qualifying stage, as qualified in REQ-024/REQ-025; index 0 is a valid register and is not excluded.
REQ-014 flush SHALL be combinational: branch_taken & ~mem_stall.
REQ-015 hazard_freeze SHALL be combinational: raw hazard & ~flush & ~mem_stall.
REQ-016 When flush and raw hazard coincide, flush SHALL win and hazard_freeze SHALL be 0.
REQ-017 While mem_stall=1, flush and hazard_freeze SHALL be 0; they are re-evaluated once the stall ends.
REQ-018 Latency from inputs to hazard_freeze, flush and mem_stall SHALL be zero cycles.
REQ-019 stall_cnt SHALL increment when hazard_freeze|mem_stall and saturate at all-ones, without wrap.

Reset
REQ-020 On rst, state SHALL be RUN, wait_cnt 0, mem_err 0 and stall_cnt 0.
REQ-021 With rst=1, hazard_freeze, flush and mem_stall SHALL be forced to 0 regardless of inputs.
REQ-022 rst asserted in MEM_WAIT or ERR SHALL return the block to RUN on the next edge, discarding the pending wait.

Configuration
REQ-023 Macro FORWARDING_EN SHALL select the hazard qualification.
REQ-024 With FORWARDING_EN defined, only EXE-stage loads SHALL qualify (exe_wb_en & exe_mem_r_en vs exe_dest); the MEM stage is ignored (load-use only, one bubble).
REQ-025 With FORWARDING_EN undefined, the EXE stage (exe_wb_en vs exe_dest) and the MEM stage (mem_wb_en vs mem_dest) SHALL both qualify.

Verification
REQ-026 Load-use: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3, use_src1=1 -> hazard_freeze=1 in both builds.
REQ-027 ALU RAW: exe_wb_en=1, exe_mem_r_en=0, exe_dest=5, two_src=1, src2=5 -> hazard_freeze=1 without FORWARDING_EN, 0 with it; mem_dest=5, mem_wb_en=1 -> same split.
REQ-028 Branch plus hazard: branch_taken=1 with the REQ-026 hazard -> flush=1, hazard_freeze=0, stall_cnt unchanged.
REQ-029 Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> mem_stall=1 for 4 cycles, 0 on the ready cycle, state back to RUN; branch_taken=1 during the wait -> flush=0.
REQ-030 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> state reaches ERR, mem_err=1, mem_stall stays 1; then rst=1 for one cycle -> RUN, mem_err=0, stall_cnt=0.
REQ-031 Saturation: CNT_W=4, mem_stall held for 20 cycles -> stall_cnt reads 15 and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It detects
// read-after-write hazards between the instruction in ID and older
// instructions, requests a flush when a branch resolves in EXE, and freezes
// the whole pipeline while the data memory is busy. A memory access that
// never completes puts the block into a sticky error state that only rst
// clears.
//
// Build option:
//   FORWARDING_EN  defined   -> the datapath forwards ALU results, so only
//                               a load in EXE (load-use) causes a bubble.
//                  undefined -> no forwarding; any pending write in EXE or
//                               MEM to a source register causes a bubble.
//
// Parameters:
//   MEM_TIMEOUT  memory wait cycles allowed before error (1..255)
//   CNT_W        width of the stall-cycle statistic counter
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   src1, src2         source register indices of the ID instruction
//   use_src1, two_src  ID instruction actually reads src1 / src2
//   exe_wb_en, exe_mem_r_en, exe_dest   ID/EXE register outputs
//   mem_wb_en, mem_dest                 EXE/MEM register outputs
//   branch_taken       branch resolving taken in EXE
//   mem_req, mem_ready MEM-stage access request / completion
//   hazard_freeze      freeze PC and IF/ID, bubble into ID/EXE
//   flush              flush IF/ID and ID/EXE
//   mem_stall          freeze every pipeline register
//   mem_err            sticky memory timeout flag (registered)
//   stall_cnt          saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hazard_freeze,
  output logic             flush,
  output logic             mem_stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Last wait_cnt value that is still tolerated; one more miss times out.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       wait_cnt_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // -------------------------------------------------------------------------
  // Raw hazard detection. Register 0 is an ordinary register here, so no
  // zero-index exclusion is applied.
  // -------------------------------------------------------------------------
  logic hit_exe;
  logic hit_mem;
  logic raw_hazard;

  assign hit_exe = (use_src1 && (src1 == exe_dest)) ||
                   (two_src  && (src2 == exe_dest));
  assign hit_mem = (use_src1 && (src1 == mem_dest)) ||
                   (two_src  && (src2 == mem_dest));

`ifdef FORWARDING_EN
  // ALU results are forwarded; only a load still in EXE has no data yet.
  logic unused_fwd;
  assign unused_fwd = ^{hit_mem, mem_wb_en};
  assign raw_hazard = exe_wb_en && exe_mem_r_en && hit_exe;
`else
  logic unused_nofwd;
  assign unused_nofwd = exe_mem_r_en;
  assign raw_hazard = (exe_wb_en && hit_exe) || (mem_wb_en && hit_mem);
`endif

  // -------------------------------------------------------------------------
  // Zero-latency control outputs. Priority: reset, memory stall, flush,
  // hazard freeze. A stalled pipeline must not act on a branch or hazard
  // because the instructions involved are not advancing.
  // -------------------------------------------------------------------------
  logic mem_stall_c;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_stall_c = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN:      mem_stall_c = mem_req && !mem_ready;
        MEM_WAIT: mem_stall_c = !mem_ready;
        ERR:      mem_stall_c = 1'b1;
        default:  mem_stall_c = 1'b0;
      endcase
    end
  end

  assign mem_stall     = mem_stall_c;
  assign flush         = !rst && branch_taken && !mem_stall_c;
  assign hazard_freeze = !rst && raw_hazard && !flush && !mem_stall_c;

  // -------------------------------------------------------------------------
  // Memory-wait FSM and stall statistic. mem_err is updated together with
  // the state so it is high exactly while the FSM sits in ERR.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q == WAIT_LAST) begin
              state_q   <= ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ERR: begin
          // Sticky until rst.
          state_q <= ERR;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 8'd0;
        end
      endcase

      if ((hazard_freeze || mem_stall_c) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl built with a short memory timeout
// and a narrow stall counter so the timeout and saturation cases are short.
// A table of single-cycle hazard vectors is followed by hand-written
// multi-cycle sequences (memory wait, reset in MEM_WAIT, timeout into ERR,
// counter saturation, reset out of ERR). Expected stall_cnt comes from a
// small saturating model advanced by the expected stall outputs.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

`ifdef FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [3:0]       src1, src2;
  logic             use_src1, two_src;
  logic             exe_wb_en, exe_mem_r_en;
  logic [3:0]       exe_dest;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             branch_taken, mem_req, mem_ready;
  logic             hazard_freeze, flush, mem_stall, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .two_src      (two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .hazard_freeze(hazard_freeze),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use_src1;
    logic       two_src;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] exe_dest;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    logic  freeze;
    logic  flush;
  } vec_t;

  typedef struct {
    logic             freeze;
    logic             flush;
    logic             stall;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] cnt_model;

  function automatic in_t hz(input logic [3:0] s1, input logic [3:0] s2,
                             input logic u1, input logic ts,
                             input logic ewb, input logic emr,
                             input logic [3:0] ed, input logic mwb,
                             input logic [3:0] md, input logic br,
                             input logic rq, input logic rdy);
    in_t v;
    v.src1 = s1;        v.src2 = s2;
    v.use_src1 = u1;    v.two_src = ts;
    v.exe_wb_en = ewb;  v.exe_mem_r_en = emr;  v.exe_dest = ed;
    v.mem_wb_en = mwb;  v.mem_dest = md;
    v.branch_taken = br; v.mem_req = rq;       v.mem_ready = rdy;
    return v;
  endfunction

  task automatic drive(input in_t v, input logic r);
    rst          = r;
    src1         = v.src1;
    src2         = v.src2;
    use_src1     = v.use_src1;
    two_src      = v.two_src;
    exe_wb_en    = v.exe_wb_en;
    exe_mem_r_en = v.exe_mem_r_en;
    exe_dest     = v.exe_dest;
    mem_wb_en    = v.mem_wb_en;
    mem_dest     = v.mem_dest;
    branch_taken = v.branch_taken;
    mem_req      = v.mem_req;
    mem_ready    = v.mem_ready;
  endtask

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (hazard_freeze !== e.freeze || flush !== e.flush ||
        mem_stall !== e.stall || mem_err !== e.err || stall_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: got frz=%b flush=%b stall=%b err=%b cnt=%0d, want frz=%b flush=%b stall=%b err=%b cnt=%0d",
               name, hazard_freeze, flush, mem_stall, mem_err, stall_cnt,
               e.freeze, e.flush, e.stall, e.err, e.cnt);
    end
  endtask

  // One clock cycle: drive just after the rising edge, push the expectation,
  // compare on the falling edge, then advance the stall counter model.
  task automatic step(input string name, input in_t v, input logic r,
                      input logic e_frz, input logic e_fl,
                      input logic e_st, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v, r);
    e.freeze = e_frz;
    e.flush  = e_fl;
    e.stall  = e_st;
    e.err    = e_err;
    e.cnt    = cnt_model;
    sb.push_back(e);
    @(negedge clk);
    check(name, sb.pop_front());
    if (r) cnt_model = '0;
    else if ((e_frz || e_st) && cnt_model != '1) cnt_model = cnt_model + 1'b1;
  endtask

  vec_t tbl[15];
  in_t  idle;
  in_t  load_use;
  in_t  req_wait;

  initial begin
    idle     = hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    load_use = hz(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 0, 0);
    req_wait = hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    //            name              inputs                                          freeze  flush
    tbl[0]  = '{"idle",           idle,                                            1'b0,   1'b0};
    tbl[1]  = '{"load_use",       load_use,                                        1'b1,   1'b0};
    tbl[2]  = '{"alu_raw_exe",    hz(0, 5, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0),          !FWD,   1'b0};
    tbl[3]  = '{"alu_raw_mem",    hz(0, 5, 0, 1, 0, 0, 9, 1, 5, 0, 0, 0),          !FWD,   1'b0};
    tbl[4]  = '{"reg0_load",      hz(0, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0),          1'b1,   1'b0};
    tbl[5]  = '{"no_use_src1",    hz(3, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0),          1'b0,   1'b0};
    tbl[6]  = '{"no_exe_wb",      hz(3, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0),          1'b0,   1'b0};
    tbl[7]  = '{"no_two_src",     hz(0, 6, 0, 0, 1, 1, 6, 1, 6, 0, 0, 0),          1'b0,   1'b0};
    tbl[8]  = '{"mem_wb_off",     hz(0, 5, 0, 1, 0, 0, 9, 0, 5, 0, 0, 0),          1'b0,   1'b0};
    tbl[9]  = '{"load_miss",      hz(4, 2, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0),          1'b0,   1'b0};
    tbl[10] = '{"src2_load",      hz(1, 8, 0, 1, 1, 1, 8, 0, 0, 0, 0, 0),          1'b1,   1'b0};
    tbl[11] = '{"branch_hazard",  hz(3, 0, 1, 0, 1, 1, 3, 0, 0, 1, 0, 0),          1'b0,   1'b1};
    tbl[12] = '{"idle_after_br",  idle,                                            1'b0,   1'b0};
    tbl[13] = '{"branch_only",    hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),          1'b0,   1'b1};
    tbl[14] = '{"mem_req_ready",  hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),          1'b0,   1'b0};

    // Bring the DUT out of its unknown power-up state.
    drive(idle, 1'b1);
    repeat (2) @(posedge clk);
    cnt_model = '0;

    // Reset forces the combinational outputs low whatever the inputs say.
    step("reset_forces_low", hz(3, 0, 1, 0, 1, 1, 3, 0, 0, 1, 1, 0), 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle hazard / flush vectors.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].name, tbl[i].in, 1'b0, tbl[i].freeze, tbl[i].flush, 1'b0, 1'b0);
    end

    // Memory wait: four stalled cycles, branch and hazard masked meanwhile,
    // stall drops in the ready cycle where the branch flush takes effect.
    step("wait_run_miss",  req_wait,                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait_hazard",    hz(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1, 0),   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait_branch",    hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0),   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait_last",      req_wait,                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait_ready",     hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1),   1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wait_back_run",  idle,                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while in MEM_WAIT discards the pending access.
    step("rw_enter",       req_wait,                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rw_waiting",     req_wait,                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rw_reset",       req_wait,                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rw_back_run",    idle,                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: RUN miss, four MEM_WAIT misses, then ERR from the sixth cycle.
    // Twenty stalled cycles also drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("timeout_%0d", i), req_wait, 1'b0,
           1'b0, 1'b0, 1'b1, (i >= 5) ? 1'b1 : 1'b0);
    end

    // ERR ignores mem_ready and masks branches.
    step("err_sticky",     hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1),   1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // One reset cycle leaves ERR; registered flags clear at that edge.
    step("err_reset",      hz(3, 0, 1, 0, 1, 1, 3, 0, 0, 1, 1, 0),   1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("after_reset",    idle,                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_rst_haz",  load_use,                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("after_rst_idle", idle,                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
